bp_sac_io_arbiter: RTL and testbench
====================================

Name: bp_sac_io_arbiter

Overview:
- Shares the streaming accelerator's single outbound I/O command channel among num_req_p local requesters (e.g. DMA engine, CSR return path) and returns in-order I/O responses to the requester that issued each command.
- Sits between the accelerator's internal engines and the socket's io_cmd/io_resp ports.
- Provides round-robin command arbitration, a registered command output stage, and an outstanding-request credit limit.
- Uses a requester-ID tag FIFO for response routing.

Parameters:
- num_req_p, 2, number of requesters (2..8).
- cmd_width_p, 128, width of one I/O command message.
- resp_width_p, 128, width of one I/O response message.
- max_outstanding_p, 4, maximum commands issued but not yet answered; also the tag FIFO depth (power of 2, ≥2).

Ports:
- clk_i, in, 1, clock.
- reset_n_i, in, 1, asynchronous active-low reset.
- req_cmd_i, in, num_req_p*cmd_width_p, per-requester command (requester k at slice k).
- req_v_i, in, num_req_p, per-requester command valid.
- req_ready_o, out, num_req_p, one-hot grant; the command is accepted when req_v_i[k] & req_ready_o[k].
- io_cmd_o, out, cmd_width_p, registered outbound command.
- io_cmd_v_o, out, 1, outbound command valid.
- io_cmd_yumi_i, in, 1, downstream consumes io_cmd_o this cycle (legal only when io_cmd_v_o=1).
- io_resp_i, in, resp_width_p, inbound response.
- io_resp_v_i, in, 1, inbound response valid.
- io_resp_ready_o, out, 1, arbiter accepts io_resp_i.
- resp_o, out, resp_width_p, response broadcast to requesters (combinational copy of io_resp_i).
- resp_v_o, out, num_req_p, response valid to the owning requester.
- resp_ready_i, in, num_req_p, requester ready for a response.
- outstanding_o, out, clog2(max_outstanding_p+1), current outstanding count.
- err_o, out, 1, sticky: a response arrived with nothing outstanding.

Behaviour:
- Reset (async assert, sync deassert internally):
  - io_cmd_v_o=0, io_cmd_o=0.
  - Outstanding count=0, tag FIFO empty, err_o=0.
  - Round-robin pointer last_grant=num_req_p-1, so requester 0 has first priority.
  - Combinational outputs (req_ready_o, resp_v_o, io_resp_ready_o) follow from these state values.
- Load condition:
  - load = (!io_cmd_v_o | io_cmd_yumi_i) & (outstanding < max_outstanding_p) & |req_v_i.
  - The credit check uses the registered count only; a response delivered in the same cycle does not free a credit until the next cycle.
- Arbitration:
  - Round-robin starting at last_grant+1 (mod num_req_p) among asserted req_v_i.
  - req_ready_o is the one-hot grant when load=1, else all zero.
  - req_ready_o depends combinationally on req_v_i; requesters must not make req_v_i depend on req_ready_o.
- On load:
  - io_cmd_o <= granted req_cmd_i slice; io_cmd_v_o <= 1.
  - Push the granted index into the tag FIFO; last_grant <= granted index.
  - The count increments on load (the command counts as outstanding from acceptance, not from yumi).
- Yumi without load: io_cmd_v_o <= 0. Yumi with load: back-to-back, one command per cycle sustained. Latency from request acceptance to io_cmd_v_o is 1 cycle.
- Output stability: io_cmd_o is held stable while io_cmd_v_o=1 and io_cmd_yumi_i=0.
- Response path:
  - head = tag FIFO head.
  - resp_v_o[k] = io_resp_v_i & !empty & (head==k).
  - io_resp_ready_o = empty | resp_ready_i[head].
  - Delivery = io_resp_v_i & !empty & resp_ready_i[head]: pop FIFO, decrement count.
- Stray response (io_resp_v_i & empty): accepted and dropped (io_resp_ready_o=1), no resp_v_o asserted, err_o <= 1. err_o is sticky until reset.
- Simultaneous load and delivery: count unchanged; FIFO push and pop both occur. The FIFO cannot overflow because load requires count < max.
- Count/FIFO wrap: FIFO pointers wrap modulo max_outstanding_p; the count saturates by construction in 0..max_outstanding_p.
- Reset mid-operation: in-flight command dropped, tags discarded, and all outputs return to reset values immediately on reset_n_i low.

Test Plan (num_req_p=2, max_outstanding_p=4):
- Reset: assert reset_n_i=0 mid-cycle -> io_cmd_v_o=0, req_ready_o=00, outstanding_o=0, err_o=0 without waiting for a clock edge.
- Fairness: req_v_i=11 held, io_cmd_yumi_i=1 every cycle, responses returned with 1-cycle lag -> grants alternate 0,1,0,1; io_cmd_o sequence matches; outstanding_o never exceeds 2.
- Credit limit: req_v_i=01, yumi every cycle, no responses -> 4 commands accepted, then req_ready_o=00 and outstanding_o=4. One response delivered -> req_ready_o[0]=1 on the following cycle, not the same cycle.
- Routing and backpressure: issue from requester 1, then requester 0; responses 0xA then 0xB -> 0xA on resp_v_o[1] and 0xB on resp_v_o[0]. While resp_ready_i[1]=0, io_resp_ready_o=0 and 0xA is held.
- Output hold: io_cmd_yumi_i=0 for 3 cycles with req_v_i=11 -> io_cmd_o stable, req_ready_o=00. Then yumi=1 -> reload in the same cycle.
- Stray response: outstanding_o=0, io_resp_v_i=1 -> io_resp_ready_o=1, resp_v_o=00, err_o=1 and remains 1 after subsequent normal traffic.

Source files
------------

// File: rtl/bp_sac_io_arbiter_if.sv
// Requester-side and socket-side signals of the streaming accelerator's I/O arbiter.
// The arbiter connects through the master modport; the environment uses slave.
interface bp_sac_io_arbiter_if #(
  parameter int num_req_p         = 2,
  parameter int cmd_width_p       = 128,
  parameter int resp_width_p      = 128,
  parameter int max_outstanding_p = 4
);
  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

  logic [num_req_p*cmd_width_p-1:0] req_cmd_i;
  logic [num_req_p-1:0]             req_v_i;
  logic [num_req_p-1:0]             req_ready_o;
  logic [cmd_width_p-1:0]           io_cmd_o;
  logic                             io_cmd_v_o;
  logic                             io_cmd_yumi_i;
  logic [resp_width_p-1:0]          io_resp_i;
  logic                             io_resp_v_i;
  logic                             io_resp_ready_o;
  logic [resp_width_p-1:0]          resp_o;
  logic [num_req_p-1:0]             resp_v_o;
  logic [num_req_p-1:0]             resp_ready_i;
  logic [cnt_width_lp-1:0]          outstanding_o;
  logic                             err_o;

  modport master (
    input  req_cmd_i, req_v_i, io_cmd_yumi_i, io_resp_i, io_resp_v_i, resp_ready_i,
    output req_ready_o, io_cmd_o, io_cmd_v_o, io_resp_ready_o, resp_o, resp_v_o,
           outstanding_o, err_o
  );

  modport slave (
    output req_cmd_i, req_v_i, io_cmd_yumi_i, io_resp_i, io_resp_v_i, resp_ready_i,
    input  req_ready_o, io_cmd_o, io_cmd_v_o, io_resp_ready_o, resp_o, resp_v_o,
           outstanding_o, err_o
  );
endinterface

// File: rtl/bp_sac_io_arbiter.sv
// Round-robin arbiter for the accelerator's single outbound I/O command channel,
// with a credit limit and a requester-ID tag FIFO that routes in-order responses.
module bp_sac_io_arbiter #(
  parameter int num_req_p         = 2,
  parameter int cmd_width_p       = 128,
  parameter int resp_width_p      = 128,
  parameter int max_outstanding_p = 4
) (
  input logic                clk_i,
  input logic                reset_n_i,
  bp_sac_io_arbiter_if.master bus
);
  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
  localparam int ptr_width_lp = $clog2(max_outstanding_p);
  localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic [1:0]              rst_sync_q;
  logic                    rst_n;
  logic [cmd_width_p-1:0]  cmd_q;
  logic                    cmd_v_q;
  logic [cnt_width_lp-1:0] cnt_q;
  logic                    err_q;
  logic [id_width_lp-1:0]  last_grant_q;
  logic [ptr_width_lp-1:0] wr_ptr_q;
  logic [ptr_width_lp-1:0] rd_ptr_q;
  logic [id_width_lp-1:0]  tag_mem [max_outstanding_p];

  logic                    grant_found;
  logic [id_width_lp-1:0]  grant_idx;
  logic [id_width_lp-1:0]  cand;
  logic [id_width_lp-1:0]  head;
  logic                    empty;
  logic                    load;
  logic                    deliver;
  logic                    stray;

  // Reset asserts asynchronously everywhere but releases two clock edges later.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = last_grant_q;
    for (int i = 0; i < num_req_p; i++) begin
      cand = (cand == id_width_lp'(num_req_p - 1)) ? '0 : cand + 1'b1;
      if (!grant_found && bus.req_v_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign empty   = (cnt_q == '0);
  assign head    = tag_mem[rd_ptr_q];
  assign load    = rst_n & (!cmd_v_q | bus.io_cmd_yumi_i)
                 & (cnt_q < cnt_width_lp'(max_outstanding_p)) & grant_found;
  assign deliver = bus.io_resp_v_i & !empty & bus.resp_ready_i[head];
  assign stray   = bus.io_resp_v_i & empty;

  always_comb begin
    bus.req_ready_o = '0;
    if (load) bus.req_ready_o[grant_idx] = 1'b1;
    bus.resp_v_o = '0;
    for (int k = 0; k < num_req_p; k++)
      bus.resp_v_o[k] = bus.io_resp_v_i & !empty & (head == id_width_lp'(k));
  end

  assign bus.io_resp_ready_o = empty | bus.resp_ready_i[head];
  assign bus.resp_o          = bus.io_resp_i;
  assign bus.io_cmd_o        = cmd_q;
  assign bus.io_cmd_v_o      = cmd_v_q;
  assign bus.outstanding_o   = cnt_q;
  assign bus.err_o           = err_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= '0;
      cmd_v_q      <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      last_grant_q <= id_width_lp'(num_req_p - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      if (load) begin
        cmd_q        <= bus.req_cmd_i[grant_idx*cmd_width_p +: cmd_width_p];
        cmd_v_q      <= 1'b1;
        last_grant_q <= grant_idx;
        wr_ptr_q     <= wr_ptr_q + 1'b1;
      end else if (bus.io_cmd_yumi_i) begin
        cmd_v_q <= 1'b0;
      end
      if (deliver) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (stray)   err_q    <= 1'b1;
      // Push and pop together leave the occupancy unchanged.
      case ({load, deliver})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: tag storage has no reset; only entries below the count are ever read, so resetting the pointers suffices.
  always_ff @(posedge clk_i) begin
    if (load) tag_mem[wr_ptr_q] <= grant_idx;
  end
endmodule

// File: tb/tb_bp_sac_io_arbiter.sv
// Bench for bp_sac_io_arbiter: a queue-based model checked every cycle, plus
// directed scenarios pinned with hand-computed literal expectations.
module tb_bp_sac_io_arbiter;
  localparam int N  = 2;
  localparam int CW = 128;
  localparam int RW = 128;
  localparam int M  = 4;
  localparam logic [CW-1:0] CMD0 = 128'hC0DE_0000;
  localparam logic [CW-1:0] CMD1 = 128'hC0DE_1111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_sac_io_arbiter_if #(.num_req_p(N), .cmd_width_p(CW), .resp_width_p(RW),
                         .max_outstanding_p(M)) bus ();

  bp_sac_io_arbiter #(.num_req_p(N), .cmd_width_p(CW), .resp_width_p(RW),
                      .max_outstanding_p(M)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus      (bus)
  );

  logic          yumi_en    = 1'b0;
  logic          resp_force = 1'b0;
  logic          resp_auto  = 1'b0;
  logic          auto_v     = 1'b0;
  logic [RW-1:0] force_data = '0;
  logic [RW-1:0] auto_data  = 128'h100;

  assign bus.io_cmd_yumi_i = yumi_en & bus.io_cmd_v_o;
  assign bus.io_resp_v_i   = resp_force | auto_v;
  assign bus.io_resp_i     = resp_force ? force_data : auto_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: outstanding tags as a queue, output stage as value+valid.
  int            mq[$];
  int            grant_log[$];
  logic [CW-1:0] cmd_log[$];
  logic [CW-1:0] m_cmd = '0;
  logic          m_v   = 1'b0;
  logic          m_err = 1'b0;
  int            m_last = N - 1;
  int            sync_cnt = 0;
  int            max_out = 0;

  logic          active, found, e_load, e_rr, m_empty, m_deliver;
  int            g, head;
  logic [N-1:0]  e_ready, e_resp_v;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_cnt = 0;
    else if (sync_cnt < 2) sync_cnt = sync_cnt + 1;
  end

  always @(posedge clk) begin
    #2;
    auto_v = resp_auto && reset_n && (mq.size() > 0);
    if (auto_v) auto_data = auto_data + 1;
  end

  always @(negedge clk) begin
    active = reset_n && (sync_cnt >= 2);
    if (!active) begin
      mq.delete();
      m_cmd  = '0;
      m_v    = 1'b0;
      m_err  = 1'b0;
      m_last = N - 1;
    end
    m_empty = (mq.size() == 0);
    head    = m_empty ? 0 : mq[0];
    found   = 1'b0;
    g       = 0;
    for (int i = 1; i <= N; i++) begin
      if (!found && bus.req_v_i[(m_last + i) % N]) begin
        found = 1'b1;
        g     = (m_last + i) % N;
      end
    end
    e_load  = active && (!m_v || bus.io_cmd_yumi_i) && (mq.size() < M) && found;
    e_ready = '0;
    if (e_load) e_ready[g] = 1'b1;
    for (int k = 0; k < N; k++) e_resp_v[k] = bus.io_resp_v_i && !m_empty && (head == k);
    e_rr      = m_empty || bus.resp_ready_i[head];
    m_deliver = bus.io_resp_v_i && !m_empty && bus.resp_ready_i[head];

    check("req_ready", bus.req_ready_o, e_ready);
    check("resp_v", bus.resp_v_o, e_resp_v);
    check("io_resp_ready", bus.io_resp_ready_o, e_rr);
    check("resp_data", bus.resp_o, bus.io_resp_i);
    check("io_cmd_v", bus.io_cmd_v_o, m_v);
    check("io_cmd", bus.io_cmd_o, m_cmd);
    check("outstanding", bus.outstanding_o, mq.size());
    check("err", bus.err_o, m_err);

    if (active) begin
      if (bus.io_cmd_yumi_i && bus.io_cmd_v_o) cmd_log.push_back(bus.io_cmd_o);
      if (bus.io_resp_v_i && m_empty) m_err = 1'b1;
      if (m_deliver) void'(mq.pop_front());
      if (e_load) begin
        mq.push_back(g);
        grant_log.push_back(g);
        m_cmd  = bus.req_cmd_i[g*CW +: CW];
        m_v    = 1'b1;
        m_last = g;
      end else if (bus.io_cmd_yumi_i) begin
        m_v = 1'b0;
      end
      if (mq.size() > max_out) max_out = mq.size();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    cmd_log.delete();
    max_out = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_cmd_i    = {CMD1, CMD0};
    bus.req_v_i      = '0;
    bus.resp_ready_i = 2'b11;

    // Power-on reset, then let the release propagate through the synchronizer.
    step(3);
    reset_n = 1'b1;
    step(3);
    check("post_reset_outstanding", bus.outstanding_o, 0);

    // Fairness: both requesting, yumi every cycle, responses one cycle behind.
    clear_logs();
    yumi_en   = 1'b1;
    resp_auto = 1'b1;
    bus.req_v_i = 2'b11;
    step(8);
    bus.req_v_i = 2'b00;
    step(6);
    resp_auto = 1'b0;
    step(1);
    check("fair_grant0", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check("fair_grant1", grant_log.size() > 1 ? grant_log[1] : -1, 1);
    check("fair_grant2", grant_log.size() > 2 ? grant_log[2] : -1, 0);
    check("fair_grant3", grant_log.size() > 3 ? grant_log[3] : -1, 1);
    check("fair_cmd0", cmd_log.size() > 0 ? cmd_log[0] : '1, CMD0);
    check("fair_cmd1", cmd_log.size() > 1 ? cmd_log[1] : '1, CMD1);
    check("fair_cmd2", cmd_log.size() > 2 ? cmd_log[2] : '1, CMD0);
    check("fair_max_out_le2", max_out <= 2, 1'b1);
    check("fair_drained", bus.outstanding_o, 0);

    // Credit limit: four commands from requester 0, no responses.
    clear_logs();
    bus.req_v_i = 2'b01;
    step(8);
    check("credit_outstanding", bus.outstanding_o, 4);
    check("credit_ready_blocked", bus.req_ready_o, 2'b00);
    check("credit_grants", grant_log.size(), 4);
    force_data = 128'h77;
    resp_force = 1'b1;
    @(negedge clk);
    check("credit_same_cycle_ready", bus.req_ready_o, 2'b00);
    check("credit_resp_v", bus.resp_v_o, 2'b01);
    step(1);
    resp_force = 1'b0;
    check("credit_next_cycle_ready", bus.req_ready_o, 2'b01);
    check("credit_after_one", bus.outstanding_o, 3);
    bus.req_v_i = 2'b00;
    resp_auto = 1'b1;
    step(6);
    resp_auto = 1'b0;
    step(1);
    check("credit_drained", bus.outstanding_o, 0);

    // Routing: requester 1 then 0; 0xA goes to 1 (held under backpressure), 0xB to 0.
    bus.req_v_i = 2'b10;
    step(1);
    bus.req_v_i = 2'b01;
    step(1);
    bus.req_v_i = 2'b00;
    step(1);
    bus.resp_ready_i = 2'b01;
    force_data = 128'hA;
    resp_force = 1'b1;
    @(negedge clk);
    check("route_a_resp_v", bus.resp_v_o, 2'b10);
    check("route_a_blocked", bus.io_resp_ready_o, 1'b0);
    check("route_a_data", bus.resp_o, 128'hA);
    step(2);
    check("route_a_held_outstanding", bus.outstanding_o, 2);
    check("route_a_held_v", bus.resp_v_o, 2'b10);
    bus.resp_ready_i = 2'b11;
    @(negedge clk);
    check("route_a_accept", bus.io_resp_ready_o, 1'b1);
    step(1);
    force_data = 128'hB;
    @(negedge clk);
    check("route_b_resp_v", bus.resp_v_o, 2'b01);
    check("route_b_data", bus.resp_o, 128'hB);
    step(1);
    resp_force = 1'b0;
    check("route_drained", bus.outstanding_o, 0);

    // Output hold: last grant was 0, so requester 1 loads; yumi low for 3 cycles.
    yumi_en = 1'b0;
    bus.req_v_i = 2'b11;
    step(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_cmd", bus.io_cmd_o, CMD1);
      check("hold_v", bus.io_cmd_v_o, 1'b1);
      check("hold_ready", bus.req_ready_o, 2'b00);
    end
    step(1);
    yumi_en = 1'b1;
    @(negedge clk);
    check("hold_reload_ready", bus.req_ready_o, 2'b01);
    step(1);
    check("hold_reload_cmd", bus.io_cmd_o, CMD0);
    bus.req_v_i = 2'b00;
    resp_auto = 1'b1;
    step(6);
    resp_auto = 1'b0;
    step(1);

    // Stray response with nothing outstanding.
    check("stray_pre_outstanding", bus.outstanding_o, 0);
    force_data = 128'h5;
    resp_force = 1'b1;
    @(negedge clk);
    check("stray_ready", bus.io_resp_ready_o, 1'b1);
    check("stray_resp_v", bus.resp_v_o, 2'b00);
    step(1);
    resp_force = 1'b0;
    check("stray_err", bus.err_o, 1'b1);
    bus.req_v_i = 2'b01;
    resp_auto = 1'b1;
    step(3);
    bus.req_v_i = 2'b00;
    step(5);
    resp_auto = 1'b0;
    step(1);
    check("stray_err_sticky", bus.err_o, 1'b1);
    check("stray_traffic_drained", bus.outstanding_o, 0);

    // Mid-cycle reset with a command in flight.
    yumi_en = 1'b0;
    bus.req_v_i = 2'b11;
    step(2);
    check("mid_reset_pre", bus.outstanding_o, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_cmd_v", bus.io_cmd_v_o, 1'b0);
    check("mid_reset_cmd", bus.io_cmd_o, 128'h0);
    check("mid_reset_ready", bus.req_ready_o, 2'b00);
    check("mid_reset_outstanding", bus.outstanding_o, 0);
    check("mid_reset_err", bus.err_o, 1'b0);
    step(2);
    reset_n = 1'b1;
    step(1);
    check("release_sync_ready", bus.req_ready_o, 2'b00);
    step(1);
    check("release_first_grant", bus.req_ready_o, 2'b01);
    bus.req_v_i = 2'b00;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
